timebase_sched: RTL and testbench
=================================

Name: timebase_sched

Overview:
- Shared timebase scheduler. One free-running prescaler is shared by four independent countdown channels.
- Each channel is configured with a period (in base ticks) and a mode (periodic / one-shot). Each can be started and stopped on its own.
- Each channel produces a 1-cycle tick pulse and a toggling square output. Display, blink and timeout logic consume these instead of instantiating private clock dividers.

Parameters:
- PRESC, 50000000, system clocks per base tick (1 Hz base at 50 MHz); legal range >= 2.
- PW, 16, width of channel period/count registers.

Ports:
- clki  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  2  target channel for config write.
- cfg_period  in  PW  period in base ticks; 0 is illegal.
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- start  in  4  per-channel start request, level sampled each cycle.
- stop  in  4  per-channel stop request, level sampled each cycle.
- base_tick  out  1  1-cycle pulse every PRESC clocks.
- ch_tick  out  4  1-cycle expiry pulse per channel.
- ch_sq  out  4  per-channel square output, toggles on each expiry.
- busy  out  4  channel in RUN state.
- cfg_err  out  1  1-cycle pulse when a config write is rejected.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Prescaler count = 0.
  - All channels IDLE, period regs = 0, mode = 0, counts = 0.
  - All outputs = 0.
  - Reset applies mid-operation with the same effect; no tick is emitted in the reset cycle.
- Prescaler:
  - pre counts 0..PRESC-1, wraps to 0, never stops.
  - base_tick is registered and high for exactly the one cycle after the edge at which pre==PRESC-1.
  - First base_tick occurs in the cycle after the PRESC-th rising edge with rst_n=1; thereafter every PRESC cycles.
- Channel FSM, two states IDLE / RUN; busy[i] = (state==RUN).
- Config write, accepted when cfg_we=1, channel cfg_ch is IDLE and cfg_period != 0:
  - Loads period and mode at that edge.
  - Otherwise the write is dropped, registers are unchanged, and cfg_err=1 for the next cycle.
- Start, IDLE -> RUN:
  - Taken when start[i]=1, period[i] != 0 and stop[i]=0. count <= period.
  - If a config write to the same channel is accepted in the same cycle, the new period/mode are used.
  - start[i] while RUN is ignored; the count is not reloaded.
  - start[i] with period 0 is ignored, with no error pulse.
- Running: on each cycle where base_tick=1:
  - If count > 1, then count <= count-1.
  - If count == 1 (expiry):
    - ch_tick[i]=1 for the next cycle and ch_sq[i] toggles at that same edge.
    - Periodic mode: count <= period and stay in RUN.
    - One-shot mode: go to IDLE; busy drops in the same cycle ch_tick rises.
- Expiry timing: ch_tick appears 1 cycle after the qualifying base_tick cycle. A period of P therefore yields expiries every P*PRESC clocks.
- Stop, RUN -> IDLE:
  - Taken when stop[i]=1. count <= 0 and ch_sq[i] <= 0. stop[i] in IDLE has no effect.
  - Stop has priority over start and over an expiry in the same cycle: no ch_tick, no toggle.
- Channels are fully independent: simultaneous expiries on several channels all tick in the same cycle.
- Arithmetic: the counter never underflows, because count==0 only occurs in IDLE. The period register is unsigned PW bits; max period is 2^PW-1.

Test Plan:
- Base tick (PRESC=4): release reset -> base_tick high in cycles 4, 8, 12, ... after release, width 1, never two adjacent cycles.
- Periodic (PRESC=4): cfg ch0 period=3 mode=0, then start[0] -> ch_tick[0] every 12 clocks, each exactly 1 cycle after a base_tick. ch_sq[0] reads 1,0,1 after the 1st, 2nd and 3rd ticks. busy[0] stays 1.
- One-shot (PRESC=4): ch2 period=2 mode=1, start -> exactly one ch_tick[2], 1 cycle after the 2nd base_tick following start. busy[2] falls in the same cycle. A further base_tick yields no tick.
- Config rejection:
  - Write ch1 while it is RUN -> cfg_err pulses 1 cycle and the period is unchanged (verified by the unchanged tick interval).
  - Write ch1 with period=0 while IDLE -> cfg_err pulses 1 cycle.
- Priority: in the base_tick cycle that would expire ch3, assert stop[3] together with start[3] -> no ch_tick[3], ch_sq[3]=0, busy[3]=0 next cycle. start[3] on a later cycle restarts with a full period.
- Reset mid-run: all four channels running, pull rst_n low for 1 edge -> all outputs 0 and periods 0. After release, start without config does nothing. base_tick timing restarts from cycle 4.

Source files
------------

// File: rtl/timebase_sched.sv
// timebase_sched: one shared prescaler generating a base tick, feeding four
// independent countdown channels (periodic or one-shot). Each channel emits a
// 1-cycle expiry pulse and a square wave that toggles on every expiry.
module timebase_sched #(
   parameter int PRESC = 50000000,
   parameter int PW    = 16
) (
   input  logic          clki,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_ch,
   input  logic [PW-1:0] cfg_period,
   input  logic          cfg_mode,
   input  logic [3:0]    start,
   input  logic [3:0]    stop,
   output logic          base_tick,
   output logic [3:0]    ch_tick,
   output logic [3:0]    ch_sq,
   output logic [3:0]    busy,
   output logic          cfg_err
);

   localparam int              PRE_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [PRE_W-1:0] pre;
   logic [0:0]       state      [4];
   logic [PW-1:0]    period     [4];
   logic [PW-1:0]    count      [4];
   logic [3:0]       mode;

   logic             cfg_ok;
   logic [3:0]       cfg_hit;
   logic [PW-1:0]    eff_period [4];

   // Config acceptance and the period a same-cycle start must use
   always_comb begin
      cfg_ok  = cfg_we && (state[cfg_ch] == S_IDLE) && (cfg_period != '0);
      cfg_hit = '0;
      if (cfg_ok) cfg_hit[cfg_ch] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         eff_period[i] = cfg_hit[i] ? cfg_period : period[i];
         busy[i]       = (state[i] == S_RUN);
      end
   end

   // Free-running prescaler; base_tick is registered one cycle after pre hits its last value
   always_ff @(posedge clki) begin
      if (!rst_n) begin
         pre       <= '0;
         base_tick <= 1'b0;
      end else begin
         base_tick <= (pre == PRE_LAST);
         pre       <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
      end
   end

   // Config registers: writes land only on idle channels with a nonzero period
   always_ff @(posedge clki) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) period[i] <= '0;
         mode    <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_ok) begin
            period[cfg_ch] <= cfg_period;
            mode[cfg_ch]   <= cfg_mode;
         end
      end
   end

   // Channel FSMs: stop beats expiry and start; count is only zero while idle
   always_ff @(posedge clki) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state[i] <= S_IDLE;
            count[i] <= '0;
         end
         ch_tick <= '0;
         ch_sq   <= '0;
      end else begin
         ch_tick <= '0;
         for (int i = 0; i < 4; i++) begin
            case (state[i])
               S_IDLE: begin
                  if (start[i] && !stop[i] && (eff_period[i] != '0)) begin
                     state[i] <= S_RUN;
                     count[i] <= eff_period[i];
                  end
               end
               default: begin
                  if (stop[i]) begin
                     state[i] <= S_IDLE;
                     count[i] <= '0;
                     ch_sq[i] <= 1'b0;
                  end else if (base_tick) begin
                     if (count[i] == PW'(1)) begin
                        ch_tick[i] <= 1'b1;
                        ch_sq[i]   <= ~ch_sq[i];
                        if (mode[i]) begin
                           state[i] <= S_IDLE;
                           count[i] <= '0;
                        end else begin
                           count[i] <= period[i];
                        end
                     end else begin
                        count[i] <= count[i] - PW'(1);
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timebase_sched.sv
// Bench for timebase_sched: directed scenarios followed by random traffic,
// every output compared each cycle against an event-level reference model.
module tb_timebase_sched;

   localparam int PRESC = 4;
   localparam int PW    = 8;

   logic          clki = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_ch = '0;
   logic [PW-1:0] cfg_period = '0;
   logic          cfg_mode = 1'b0;
   logic [3:0]    start = '0;
   logic [3:0]    stop = '0;
   logic          base_tick;
   logic [3:0]    ch_tick;
   logic [3:0]    ch_sq;
   logic [3:0]    busy;
   logic          cfg_err;

   timebase_sched #(.PRESC(PRESC), .PW(PW)) dut (
      .clki(clki), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_mode(cfg_mode), .start(start), .stop(stop),
      .base_tick(base_tick), .ch_tick(ch_tick), .ch_sq(ch_sq), .busy(busy),
      .cfg_err(cfg_err)
   );

   always #5 clki = ~clki;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: cycles since reset release, and per-channel remaining base ticks
   int m_cyc = 0;
   bit m_base = 0;
   bit m_err = 0;
   bit m_run  [4] = '{default: 0};
   int m_per  [4] = '{default: 0};
   bit m_mode [4] = '{default: 0};
   int m_rem  [4] = '{default: 0};
   bit m_sq   [4] = '{default: 0};
   bit m_tick [4] = '{default: 0};

   task automatic step(input logic rn, input logic we, input logic [1:0] ch,
                       input logic [PW-1:0] per, input logic md,
                       input logic [3:0] st, input logic [3:0] sp);
      logic [3:0] e_tick, e_sq, e_busy;
      bit nb;
      @(negedge clki);
      for (int i = 0; i < 4; i++) begin
         e_tick[i] = m_tick[i];
         e_sq[i]   = m_sq[i];
         e_busy[i] = m_run[i];
      end
      chk("base_tick", {31'd0, base_tick}, {31'd0, m_base});
      chk("ch_tick",   {28'd0, ch_tick},   {28'd0, e_tick});
      chk("ch_sq",     {28'd0, ch_sq},     {28'd0, e_sq});
      chk("busy",      {28'd0, busy},      {28'd0, e_busy});
      chk("cfg_err",   {31'd0, cfg_err},   {31'd0, m_err});
      rst_n = rn; cfg_we = we; cfg_ch = ch; cfg_period = per; cfg_mode = md;
      start = st; stop = sp;
      if (!rn) begin
         m_cyc = 0; m_base = 0; m_err = 0;
         for (int i = 0; i < 4; i++) begin
            m_run[i] = 0; m_per[i] = 0; m_mode[i] = 0;
            m_rem[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
         end
      end else begin
         m_cyc++;
         nb = (m_cyc % PRESC) == 0;
         m_err = 0;
         if (we) begin
            if (!m_run[ch] && per != 0) begin
               m_per[ch]  = int'(per);
               m_mode[ch] = md;
            end else begin
               m_err = 1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            m_tick[i] = 0;
            if (m_run[i]) begin
               if (sp[i]) begin
                  m_run[i] = 0; m_rem[i] = 0; m_sq[i] = 0;
               end else if (m_base) begin
                  m_rem[i] = m_rem[i] - 1;
                  if (m_rem[i] == 0) begin
                     m_tick[i] = 1;
                     m_sq[i]   = !m_sq[i];
                     if (m_mode[i]) m_run[i] = 0;
                     else           m_rem[i] = m_per[i];
                  end
               end
            end else if (st[i] && !sp[i] && m_per[i] != 0) begin
               m_run[i] = 1;
               m_rem[i] = m_per[i];
            end
         end
         m_base = nb;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h0, 4'h0);
   endtask

   initial begin
      logic [3:0] rs, rp;
      // reset state
      @(negedge clki);
      chk("rst_base_tick", {31'd0, base_tick}, 32'd0);
      chk("rst_busy",      {28'd0, busy},      32'd0);
      chk("rst_ch_sq",     {28'd0, ch_sq},     32'd0);
      chk("rst_ch_tick",   {28'd0, ch_tick},   32'd0);
      chk("rst_cfg_err",   {31'd0, cfg_err},   32'd0);
      step(1'b0, 1'b0, 2'd0, '0, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b0, 2'd0, '0, 1'b0, 4'h0, 4'h0);
      idle(14);

      // periodic channel 0, period 3
      step(1'b1, 1'b1, 2'd0, 8'd3, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h1, 4'h0);
      idle(40);

      // one-shot channel 2, period 2, with config and start together
      step(1'b1, 1'b1, 2'd2, 8'd2, 1'b1, 4'h4, 4'h0);
      idle(16);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h1, 4'h0);   // start while running: ignored

      // config rejection on channel 1
      step(1'b1, 1'b1, 2'd1, 8'd2, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h2, 4'h0);
      idle(3);
      step(1'b1, 1'b1, 2'd1, 8'd5, 1'b1, 4'h0, 4'h0);  // running: rejected
      idle(30);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h0, 4'h2);
      step(1'b1, 1'b1, 2'd1, 8'd0, 1'b0, 4'h0, 4'h0);  // period 0: rejected
      idle(2);

      // stop + start held across an expiring base tick on channel 3
      step(1'b1, 1'b1, 2'd3, 8'd1, 1'b0, 4'h8, 4'h0);
      idle(2);
      for (int k = 0; k < PRESC + 1; k++) step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h8, 4'h8);
      idle(3);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'h8, 4'h0);
      idle(12);

      // reset mid-run with all channels active
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 2'(c), 8'(c + 1), 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'hF, 4'h0);
      idle(10);
      step(1'b0, 1'b0, 2'd0, '0, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 2'd0, '0, 1'b0, 4'hF, 4'h0);
      idle(14);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 4; b++) begin
            rs[b] = ($urandom_range(0, 7) == 0);
            rp[b] = ($urandom_range(0, 39) == 0);
         end
         step(($urandom_range(0, 399) != 0),
              ($urandom_range(0, 5) == 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 5)),
              1'($urandom_range(0, 1)),
              rs, rp);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
